// File: rtl/cra_diag_seq_pkg.sv
// cra_diag_seq_pkg: shared types and CRA diagnostic function select codes.
//   tCRADR        11-bit CRAM address, bit 0 is the MSB
//   tCraDiagOp    host command opcode
//   tCraDiagState sequencer state
//   rd_code       read slice select for an opcode and half
package cra_diag_seq_pkg;
    typedef logic [0:10] tCRADR;
    typedef enum logic [1:0] {
        OP_LOAD_ADR,
        OP_READ_CRADR,
        OP_READ_SBR_RET,
        OP_READ_STATUS
    } tCraDiagOp;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_SETUP,
        S_LD_STROBE,
        S_LD_HOLD,
        S_RD_WAIT,
        S_RSP
    } tCraDiagState;
    localparam logic [2:0] DIAG_LD_051 = 3'o1;
    localparam logic [2:0] DIAG_LD_052 = 3'o2;
    localparam logic [2:0] DIAG_RD_140 = 3'o0;
    localparam logic [2:0] DIAG_RD_142 = 3'o2;
    localparam logic [2:0] DIAG_RD_144 = 3'o4;
    // Each read pair differs only in the LSB, which selects the high slice.
    function automatic logic [2:0] rd_code(input tCraDiagOp op, input logic h);
        return (op == OP_READ_CRADR   ? DIAG_RD_144 :
                op == OP_READ_SBR_RET ? DIAG_RD_142 : DIAG_RD_140) | {2'b00, h};
    endfunction
endpackage

// File: rtl/cra_diag_seq.sv
// cra_diag_seq: turns one host command into a two-slice CRA diagnostic load/read sequence.
//   cmdValid/cmdReady/cmdOp/cmdAdr  host command handshake
//   diagLoadFunc05x, diagReadFunc14x, diag  CTL diagnostic function controls
//   ebusDrive/ebusOut/ebusIn        EBUS data[0:5]
//   rspValid/rspReady/rspData/rspFlag/rspStat  held response
module cra_diag_seq
    import cra_diag_seq_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [0:10] cmdAdr,
    output logic        diagLoadFunc05x,
    output logic        diagReadFunc14x,
    output logic [4:6]  diag,
    output logic        ebusDrive,
    output logic [0:5]  ebusOut,
    input  logic [0:5]  ebusIn,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:10] rspData,
    output logic        rspFlag,
    output logic [0:10] rspStat
);
    tCraDiagState st;
    tCraDiagOp    op;
    tCRADR        adr;
    logic         h;
    logic [3:0]   cnt;
    // Holds cmdReady low for the first cycle out of reset.
    logic         armed;
    logic         ld;
    logic         rd;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            st      <= S_IDLE;
            op      <= OP_LOAD_ADR;
            adr     <= '0;
            h       <= 1'b0;
            cnt     <= '0;
            armed   <= 1'b0;
            rspData <= '0;
            rspFlag <= 1'b0;
            rspStat <= '0;
        end else begin
            armed <= 1'b1;
            case (st)
                S_IDLE: if (cmdValid && armed) begin
                    op      <= tCraDiagOp'(cmdOp);
                    adr     <= cmdAdr;
                    h       <= 1'b0;
                    cnt     <= '0;
                    rspData <= '0;
                    rspFlag <= 1'b0;
                    rspStat <= '0;
                    st      <= tCraDiagOp'(cmdOp) == OP_LOAD_ADR ? S_LD_SETUP : S_RD_WAIT;
                end
                S_LD_SETUP:  st <= S_LD_STROBE;
                S_LD_STROBE: st <= S_LD_HOLD;
                S_LD_HOLD: if (!h) begin
                    h  <= 1'b1;
                    st <= S_LD_SETUP;
                end else begin
                    rspData <= adr;
                    st      <= S_RSP;
                end
                S_RD_WAIT: if (cnt == 4'(SETTLE)) begin
                    cnt <= '0;
                    if (!h) begin
                        h <= 1'b1;
                        if (op == OP_READ_STATUS) rspStat[0:5] <= ebusIn;
                        else rspData[5:10] <= ebusIn;
                    end else begin
                        // High slice: bit 0 is the flag, bits 1..5 extend the address.
                        if (op == OP_READ_STATUS) rspStat[6:10] <= ebusIn[1:5];
                        else begin
                            rspFlag      <= ebusIn[0];
                            rspData[0:4] <= ebusIn[1:5];
                        end
                        st <= S_RSP;
                    end
                end else cnt <= cnt + 4'd1;
                S_RSP: if (rspReady) st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    assign ld              = st == S_LD_SETUP || st == S_LD_STROBE || st == S_LD_HOLD;
    assign rd              = st == S_RD_WAIT;
    assign cmdReady        = armed && st == S_IDLE;
    assign rspValid        = st == S_RSP;
    assign ebusDrive       = ld;
    assign diagLoadFunc05x = st == S_LD_STROBE;
    assign diagReadFunc14x = rd;
    assign diag            = ld ? (h ? DIAG_LD_052 : DIAG_LD_051) : rd ? rd_code(op, h) : 3'b000;
    assign ebusOut         = ld ? (h ? {1'b0, adr[0:4]} : adr[5:10]) : 6'b000000;
endmodule
